// File: rtl/bli201_pkg.sv
// bli201_pkg: shared state encoding and constants for the BLI201 fetch path.
package bli201_pkg;
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_HALT} state_t;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous {pc, inst} buffer with push, pop, flush, count, full and empty.
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout  = mem[rd_ptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/ifu.sv
// ifu: BLI201 instruction fetch unit; credit-limited word fetch into a small buffer feeding decode.
// Optional BLI201_IFU_MISALIGN_CHK_EN halts on misaligned redirects and adds ifu_o_misalign.
module ifu
  import bli201_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_o_mem_req_valid,
  input  logic        ifu_i_mem_req_ready,
  output logic [31:0] ifu_o_mem_addr,
  input  logic        ifu_i_mem_rsp_valid,
  input  logic [31:0] ifu_i_mem_rsp_data,
  output logic        ifu_o_inst_valid,
  input  logic        ifu_i_inst_ready,
  output logic [31:0] ifu_o_inst,
  output logic [31:0] ifu_o_pc,
  input  logic        ifu_i_redirect,
  input  logic [31:0] ifu_i_redirect_pc
`ifdef BLI201_IFU_MISALIGN_CHK_EN
  ,
  output logic        ifu_o_misalign
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  logic [31:0] req_pc, rsp_pc, tgt;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [63:0] head;
  logic req_hs, push, pop, full, empty;
  always_comb begin
`ifdef BLI201_IFU_MISALIGN_CHK_EN
    state_n = ifu_i_redirect ? (|ifu_i_redirect_pc[1:0] ? S_HALT : S_FETCH)
                             : (state == S_HALT ? S_HALT : S_FETCH);
    tgt     = ifu_i_redirect_pc;
`else
    state_n = S_FETCH;
    tgt     = ifu_i_redirect_pc & ~32'h3;
`endif
  end
`ifdef BLI201_IFU_MISALIGN_CHK_EN
  assign ifu_o_misalign = state == S_HALT;
`endif
  // Requests and buffered words together never exceed the buffer, so responses always fit.
  assign ifu_o_mem_req_valid = state == S_FETCH && !ifu_i_redirect &&
                               ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);
  assign ifu_o_mem_addr      = req_pc;
  assign req_hs              = ifu_o_mem_req_valid && ifu_i_mem_req_ready;
  assign push                = ifu_i_mem_rsp_valid && !ifu_i_redirect && drop_cnt == '0;
  assign pop                 = ifu_o_inst_valid && ifu_i_inst_ready;
  assign ifu_o_inst_valid    = !empty;
  assign ifu_o_pc            = head[63:32];
  assign ifu_o_inst          = head[31:0];
  ifu_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (ifu_i_redirect),
    .din   ({rsp_pc, ifu_i_mem_rsp_data}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      req_pc      <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_n;
      outstanding <= outstanding + CW'(req_hs) - CW'(ifu_i_mem_rsp_valid);
      if (ifu_i_redirect) begin
        req_pc   <= tgt;
        rsp_pc   <= tgt;
        drop_cnt <= outstanding - CW'(ifu_i_mem_rsp_valid);
      end else begin
        if (req_hs) req_pc <= req_pc + 32'd4;
        if (push) rsp_pc <= rsp_pc + 32'd4;
        if (ifu_i_mem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
      if (full && push) assert (pop);
    end
  end
endmodule
